// File: rtl/pc_alu_branch_unit_if.sv
// rtl/pc_alu_branch_unit_if.sv - fetch-control / ALU / branch signal bundle
interface pc_alu_branch_unit_if;
  logic        pc_src;
  logic [31:0] jump_addr;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  alu_op;
  logic [2:0]  branch_type;
  logic [31:0] i_addr;
  logic        can_write;
  logic [31:0] result;
  logic        zero;
  logic        neg;
  logic        c_out;
  logic        over;
  logic        branch_taken;

  modport master (
    output pc_src, jump_addr, A, B, alu_op, branch_type,
    input  i_addr, can_write, result, zero, neg, c_out, over, branch_taken
  );

  modport slave (
    input  pc_src, jump_addr, A, B, alu_op, branch_type,
    output i_addr, can_write, result, zero, neg, c_out, over, branch_taken
  );
endinterface

// File: rtl/pc_alu_branch_unit.sv
// rtl/pc_alu_branch_unit.sv - PC sequencer, 32-bit ALU and branch decider (option: PCU_UNSIGNED_BRANCH_EN)
module pc_alu_branch_unit #(
  parameter int          PHASES   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  pc_alu_branch_unit_if.slave bus
);
  localparam int PW = (PHASES > 2) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [31:0]   i_addr_q, i_addr_d;
  logic          can_write_q, can_write_d;

  // Next-state: advance phase; PC moves only when leaving the last phase
  always_comb begin
    phase_d     = phase_q + PW'(1);
    i_addr_d    = i_addr_q;
    if (phase_q == LAST) begin
      phase_d = '0;
      if (bus.pc_src) begin
        i_addr_d = bus.jump_addr & 32'hFFFF_FFFC;
      end else begin
        i_addr_d = i_addr_q + 32'd4;
      end
    end
    can_write_d = (phase_d == LAST);
  end

  // State registers; reset takes effect without waiting for the clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= '0;
      i_addr_q    <= RESET_PC;
      can_write_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      i_addr_q    <= i_addr_d;
      can_write_q <= can_write_d;
    end
  end

  assign bus.i_addr    = i_addr_q;
  assign bus.can_write = can_write_q;

  logic [32:0] add_sum, sub_sum;
  logic [31:0] res;
  logic        c_flag, v_flag;

  assign add_sum = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_sum = {1'b0, bus.A} + {1'b0, ~bus.B} + 33'd1;

  // ALU result and arithmetic flags; carry/overflow only meaningful for ADD/SUB
  always_comb begin
    res    = 32'd0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (bus.alu_op)
      3'b000: begin
        res    = add_sum[31:0];
        c_flag = add_sum[32];
        v_flag = (bus.A[31] == bus.B[31]) && (add_sum[31] != bus.A[31]);
      end
      3'b001: begin
        res    = sub_sum[31:0];
        c_flag = sub_sum[32];
        v_flag = (bus.A[31] != bus.B[31]) && (sub_sum[31] != bus.A[31]);
      end
      3'b010:  res = bus.A & bus.B;
      3'b011:  res = bus.A | bus.B;
      3'b100:  res = bus.A ^ bus.B;
      default: res = 32'd0;
    endcase
  end

  assign bus.result = res;
  assign bus.zero   = (res == 32'd0);
  assign bus.neg    = res[31];
  assign bus.c_out  = c_flag;
  assign bus.over   = v_flag;

  // Branch decision from the flags of the (caller-selected) SUB
  always_comb begin
    bus.branch_taken = 1'b0;
    case (bus.branch_type)
      3'b000: bus.branch_taken = bus.zero;
      3'b001: bus.branch_taken = !bus.zero;
      3'b100: bus.branch_taken = bus.neg ^ bus.over;
      3'b101: bus.branch_taken = !(bus.neg ^ bus.over);
`ifdef PCU_UNSIGNED_BRANCH_EN
      3'b110: bus.branch_taken = !bus.c_out;
      3'b111: bus.branch_taken = bus.c_out;
`else
      3'b110: bus.branch_taken = 1'b0;
      3'b111: bus.branch_taken = 1'b0;
`endif
      default: bus.branch_taken = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_pc_alu_branch_unit.sv
// tb/tb_pc_alu_branch_unit.sv - directed-vector bench for pc_alu_branch_unit
module tb_pc_alu_branch_unit;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

`ifdef PCU_UNSIGNED_BRANCH_EN
  localparam logic UBR = 1'b1;
`else
  localparam logic UBR = 1'b0;
`endif

  pc_alu_branch_unit_if bus ();

  pc_alu_branch_unit #(.PHASES(5), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // op, A, B, branch_type, expected result, expected {zero,neg,c_out,over}, expected taken
  task automatic alu_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] bt, input logic [31:0] er,
                         input logic [3:0] ef, input logic et);
    bus.alu_op      = op;
    bus.A           = a;
    bus.B           = b;
    bus.branch_type = bt;
    #1;
    check({tag, ".result"}, bus.result, er);
    check({tag, ".flags"}, {28'd0, bus.zero, bus.neg, bus.c_out, bus.over}, {28'd0, ef});
    check({tag, ".taken"}, {31'd0, bus.branch_taken}, {31'd0, et});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset           = 1'b0;
    bus.pc_src      = 1'b0;
    bus.jump_addr   = 32'd0;
    bus.A           = 32'd0;
    bus.B           = 32'd0;
    bus.alu_op      = 3'b000;
    bus.branch_type = 3'b010;

    #2;
    check("rst.i_addr", bus.i_addr, 32'd0);
    check("rst.can_write", {31'd0, bus.can_write}, 32'd0);
    repeat (2) step();
    check("rst_hold.i_addr", bus.i_addr, 32'd0);

    // Release reset between edges
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch: edges 1..15 after deassertion
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("seq%0d.i_addr", k), bus.i_addr, 32'(4 * (k / 5)));
      check($sformatf("seq%0d.can_write", k), {31'd0, bus.can_write}, {31'd0, (k % 5) == 4});
    end

    // Jump held through the whole period (now in phase 0, i_addr=12)
    bus.jump_addr = 32'h0000_0103;
    bus.pc_src    = 1'b1;
    repeat (4) step();
    check("jmp.pre.i_addr", bus.i_addr, 32'd12);
    step();
    check("jmp.i_addr", bus.i_addr, 32'h0000_0100);
    bus.pc_src    = 1'b0;
    bus.jump_addr = 32'h0000_0200;

    // pc_src asserted only during phase 2 is ignored
    repeat (2) step();
    bus.pc_src = 1'b1;
    step();
    bus.pc_src = 1'b0;
    repeat (2) step();
    check("jmp_ph2.i_addr", bus.i_addr, 32'h0000_0104);

    // Reach i_addr=0x40, then reset in phase 3 with a jump pending
    bus.jump_addr = 32'h0000_0040;
    bus.pc_src    = 1'b1;
    repeat (5) step();
    check("to40.i_addr", bus.i_addr, 32'h0000_0040);
    bus.jump_addr = 32'h0000_0800;
    repeat (3) step();
    check("ph3.i_addr", bus.i_addr, 32'h0000_0040);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst.i_addr", bus.i_addr, 32'd0);
    check("async_rst.can_write", {31'd0, bus.can_write}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.pc_src = 1'b0;
    repeat (4) step();
    check("rst2.can_write", {31'd0, bus.can_write}, 32'd1);
    step();
    check("rst2.i_addr", bus.i_addr, 32'd4);

    // ALU / branch vectors
    alu_vec("sub55_beq",  3'b001, 32'd5, 32'd5, 3'b000, 32'd0, 4'b1010, 1'b1);
    alu_vec("sub55_bne",  3'b001, 32'd5, 32'd5, 3'b001, 32'd0, 4'b1010, 1'b0);
    alu_vec("sub55_bgeu", 3'b001, 32'd5, 32'd5, 3'b111, 32'd0, 4'b1010, UBR);
    alu_vec("subm1_blt",  3'b001, 32'hFFFF_FFFF, 32'd1, 3'b100, 32'hFFFF_FFFE, 4'b0110, 1'b1);
    alu_vec("subm1_bge",  3'b001, 32'hFFFF_FFFF, 32'd1, 3'b101, 32'hFFFF_FFFE, 4'b0110, 1'b0);
    alu_vec("subm1_bltu", 3'b001, 32'hFFFF_FFFF, 32'd1, 3'b110, 32'hFFFF_FFFE, 4'b0110, 1'b0);
    alu_vec("subm1_bgeu", 3'b001, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'hFFFF_FFFE, 4'b0110, UBR);
    alu_vec("sub12_bltu", 3'b001, 32'd1, 32'd2, 3'b110, 32'hFFFF_FFFF, 4'b0100, UBR);
    alu_vec("subovf_blt", 3'b001, 32'h8000_0000, 32'd1, 3'b100, 32'h7FFF_FFFF, 4'b0011, 1'b1);
    alu_vec("addovf",     3'b000, 32'h7FFF_FFFF, 32'd1, 3'b100, 32'h8000_0000, 4'b0101, 1'b0);
    alu_vec("addwrap",    3'b000, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 4'b1010, 1'b1);
    alu_vec("and",        3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 32'h00F0_00F0, 4'b0000, 1'b0);
    alu_vec("or",         3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b011, 32'hFFF0_FFF0, 4'b0100, 1'b0);
    alu_vec("xor",        3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 32'hFF00_FF00, 4'b0100, 1'b1);
    alu_vec("op101",      3'b101, 32'h1234_5678, 32'd1, 3'b010, 32'd0, 4'b1000, 1'b0);
    alu_vec("op111",      3'b111, 32'hFFFF_FFFF, 32'd1, 3'b000, 32'd0, 4'b1000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_alu_branch_unit.md
# pc_alu_branch_unit

Combined fetch-control and execute core for the RV32I-style multi-cycle CPU. It holds the program counter, sequences the fixed-length instruction period, and provides the 32-bit ALU with its condition flags. It also decides conditional branches from those flags. It sits between instruction memory (fed by `i_addr`) and the writeback/memory-write gating (fed by `can_write`).

## Interface
- `PHASES`, default 5: clock cycles per instruction period (minimum 2).
- `RESET_PC`, default 32'h0000_0000: value of `i_addr` after reset.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0).
- `pc_src` input 1: 1 selects `jump_addr` for the next PC; 0 selects sequential.
- `jump_addr` input 32: redirect target.
- `A` input 32: ALU operand A.
- `B` input 32: ALU operand B.
- `alu_op` input 3: ALU operation.
- `branch_type` input 3: branch condition, RISC-V funct3 encoding.
- `i_addr` output 32: current instruction address (registered).
- `can_write` output 1: architectural-write enable (registered).
- `result` output 32: ALU result.
- `zero`, `neg`, `c_out`, `over` output 1 each: ALU flags.
- `branch_taken` output 1: branch condition satisfied.

## Operation
- Phase counter `phase` runs 0 .. PHASES-1 and wraps to 0.
- `can_write` = 1 exactly while `phase == PHASES-1`; it is 0 otherwise.
- PC update on the rising edge leaving phase PHASES-1:
  - `pc_src=1`: `i_addr <= {jump_addr[31:2], 2'b00}`.
  - `pc_src=0`: `i_addr <= i_addr + 4`, modulo 2^32 (wraps FFFF_FFFC -> 0000_0000).
  - In all other phases `i_addr` holds.
- ALU is combinational, with `alu_op` encodings:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101–111: result 0.
- Flags:
  - `zero` = (result==0).
  - `neg` = result[31].
  - `c_out` = carry out of bit 31 for ADD/SUB; for SUB, 1 means A ≥ B unsigned.
  - `over` = signed overflow for ADD/SUB.
  - `c_out` and `over` = 0 for all other ops.
- `branch_decider` is combinational from the flags (the caller drives SUB):
  - 000 BEQ: `zero`.
  - 001 BNE: `!zero`.
  - 100 BLT: `neg^over`.
  - 101 BGE: `!(neg^over)`.
  - 110 BLTU: `!c_out`.
  - 111 BGEU: `c_out`.
  - 010, 011: 0 (no branch).

## Timing
- Reset asserted: immediately `i_addr=RESET_PC`, `phase=0`, `can_write=0`, independent of `clk`.
- Reset deassertion:
  - First period begins at the next rising edge.
  - `can_write` first rises PHASES-1 edges later.
  - First PC change occurs PHASES edges after deassertion.
- Reset asserted mid-period aborts the period; pending `pc_src`/`jump_addr` are discarded.
- `pc_src`/`jump_addr` are sampled only on the edge that ends phase PHASES-1; values in other phases are ignored.
- ALU and branch outputs have zero latency and settle combinationally from `A`, `B`, `alu_op`, `branch_type`.

## Configuration
- `PCU_UNSIGNED_BRANCH_EN` defined: BLTU (110) and BGEU (111) are decoded as specified.
- `PCU_UNSIGNED_BRANCH_EN` undefined:
  - `branch_type` 110 and 111 force `branch_taken=0`.
  - The ALU and `c_out` are unchanged.

## Test plan
- Reset low then high, `pc_src=0`, PHASES=5: `i_addr`=0 for 5 edges, then 4, 8, 12 at every 5th edge. `can_write` pulses high one cycle in each period, aligned with phase 4.
- `jump_addr=0x0000_0103`, `pc_src=1` held through phase 4: next `i_addr=0x0000_0100`. With `pc_src=1` only in phase 2, PC increments by 4 instead.
- SUB with A=5, B=5: `result=0`, `zero=1`, `c_out=1`. BEQ gives taken=1, BNE gives taken=0, BGEU gives taken=1.
- SUB with A=0xFFFF_FFFF, B=1: `neg=1`, `over=0`. BLT gives taken=1. BLTU gives taken=0 with the macro; without the macro, BLTU/BGEU give 0.
- ADD with A=0x7FFF_FFFF, B=1: `result=0x8000_0000`, `over=1`, `neg=1`, `c_out=0`. AND/OR/XOR spot values are correct with `c_out=over=0`.
- Reset asserted at phase 3 with `i_addr=0x40`: `i_addr=0` and `can_write=0` without waiting for a clock edge.
